// File: rtl/kbd_pkg.sv
// Shared keyboard codes, echo operations and controller states for the line input path.
package kbd_pkg;

  localparam logic [7:0] KC_DELETE    = 8'd37;
  localparam logic [7:0] KC_ESC       = 8'd39;
  localparam logic [7:0] KC_ENTER     = 8'd98;
  localparam logic [7:0] KC_UP        = 8'd99;
  localparam logic [7:0] KC_DOWN      = 8'd100;
  localparam logic [7:0] KC_LEFT      = 8'd101;
  localparam logic [7:0] KC_RIGHT     = 8'd102;
  localparam logic [7:0] KC_UNKNOWN   = 8'd255;
  localparam logic [7:0] KC_PRINT_MAX = 8'd39;

  typedef enum logic [1:0] {
    ECHO_WRITE = 2'd0,
    ECHO_ERASE = 2'd1,
    ECHO_CLEAR = 2'd2
  } echo_op_e;

  typedef enum logic {
    ST_EDIT = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  // Printable codes are 0..39 minus delete (37) and esc (39).
  function automatic logic is_printable(input logic [7:0] kc);
    return (kc <= KC_PRINT_MAX) && (kc != KC_DELETE) && (kc != KC_ESC);
  endfunction

endpackage

// File: rtl/line_input_controller_if.sv
// Keystroke, commit/ack, read-port and echo signals of the line input controller.
interface line_input_controller_if #(
  parameter int unsigned MAX_LEN = 32
);
  localparam int unsigned LEN_W  = $clog2(MAX_LEN) + 1;
  localparam int unsigned ADDR_W = $clog2(MAX_LEN);

  logic              key_pressed;
  logic [7:0]        keycode;
  logic              line_ready;
  logic [LEN_W-1:0]  line_len;
  logic              line_ack;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic              overflow;
  logic              echo_valid;
  logic [1:0]        echo_op;
  logic [ADDR_W-1:0] echo_pos;
  logic [7:0]        echo_char;

  // Keyboard/processor/display side.
  modport master (
    output key_pressed, keycode, line_ack, rd_addr,
    input  line_ready, line_len, rd_data, overflow,
    input  echo_valid, echo_op, echo_pos, echo_char
  );

  // Controller side.
  modport slave (
    input  key_pressed, keycode, line_ack, rd_addr,
    output line_ready, line_len, rd_data, overflow,
    output echo_valid, echo_op, echo_pos, echo_char
  );
endinterface

// File: rtl/line_buffer_ram.sv
// MAX_LEN x 8 line storage: one synchronous write port, one registered read port.
module line_buffer_ram #(
  parameter int unsigned MAX_LEN = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic [$clog2(MAX_LEN)-1:0] waddr,
  input  logic [7:0]                 wdata,
  input  logic [$clog2(MAX_LEN)-1:0] raddr,
  output logic [7:0]                 rdata
);
  logic [7:0] mem [MAX_LEN];

  // Array write; contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read; same-address write returns the old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata <= 8'd0;
    else     rdata <= mem[raddr];
  end
endmodule

// File: rtl/line_input_controller.sv
// Edits keystrokes into a bounded line buffer, holds committed lines until ack, echoes changes.
module line_input_controller
  import kbd_pkg::*;
#(
  parameter int unsigned MAX_LEN = 32
) (
  input logic                    CLOCK_50,
  input logic                    reset,
  line_input_controller_if.slave bus
);
  localparam int unsigned LEN_W  = $clog2(MAX_LEN) + 1;
  localparam int unsigned ADDR_W = $clog2(MAX_LEN);

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              ready_q, ready_d;
  logic              ovf_q, ovf_d;
  logic              ev_q, ev_d;
  echo_op_e          op_q, op_d;
  logic [ADDR_W-1:0] pos_q, pos_d;
  logic [7:0]        ch_q, ch_d;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [7:0]        wdata;
  logic [7:0]        rd_data_w;

  // Next-state, buffer write and echo decode.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    ready_d = ready_q;
    ovf_d   = ovf_q;
    ev_d    = 1'b0;
    op_d    = op_q;
    pos_d   = pos_q;
    ch_d    = ch_q;
    we      = 1'b0;
    waddr   = ADDR_W'(len_q);
    wdata   = bus.keycode;
    case (state_q)
      ST_EDIT: begin
        if (bus.key_pressed) begin
          if (is_printable(bus.keycode)) begin
            if (len_q < LEN_W'(MAX_LEN)) begin
              we    = 1'b1;
              len_d = len_q + LEN_W'(1);
              ev_d  = 1'b1;
              op_d  = ECHO_WRITE;
              pos_d = ADDR_W'(len_q);
              ch_d  = bus.keycode;
            end else begin
              ovf_d = 1'b1;
            end
          end else if (bus.keycode == KC_DELETE) begin
            if (len_q != '0) begin
              len_d = len_q - LEN_W'(1);
              ev_d  = 1'b1;
              op_d  = ECHO_ERASE;
              pos_d = ADDR_W'(len_q - LEN_W'(1));
              ch_d  = 8'd0;
            end
          end else if (bus.keycode == KC_ESC) begin
            len_d = '0;
            ovf_d = 1'b0;
            ev_d  = 1'b1;
            op_d  = ECHO_CLEAR;
            pos_d = '0;
            ch_d  = 8'd0;
          end else if (bus.keycode == KC_ENTER) begin
            state_d = ST_HOLD;
            ready_d = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        // Keys are dropped while holding, including one coinciding with the ack.
        if (bus.line_ack) begin
          state_d = ST_EDIT;
          ready_d = 1'b0;
          len_d   = '0;
          ovf_d   = 1'b0;
          ev_d    = 1'b1;
          op_d    = ECHO_CLEAR;
          pos_d   = '0;
          ch_d    = 8'd0;
        end
      end
      default: state_d = ST_EDIT;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q <= ST_EDIT;
      len_q   <= '0;
      ready_q <= 1'b0;
      ovf_q   <= 1'b0;
      ev_q    <= 1'b0;
      op_q    <= ECHO_WRITE;
      pos_q   <= '0;
      ch_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      ready_q <= ready_d;
      ovf_q   <= ovf_d;
      ev_q    <= ev_d;
      op_q    <= op_d;
      pos_q   <= pos_d;
      ch_q    <= ch_d;
    end
  end

  line_buffer_ram #(
    .MAX_LEN(MAX_LEN)
  ) u_ram (
    .clk   (CLOCK_50),
    .rst   (reset),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (bus.rd_addr),
    .rdata (rd_data_w)
  );

  assign bus.line_ready = ready_q;
  assign bus.line_len   = len_q;
  assign bus.overflow   = ovf_q;
  assign bus.echo_valid = ev_q;
  assign bus.echo_op    = op_q;
  assign bus.echo_pos   = pos_q;
  assign bus.echo_char  = ch_q;
  assign bus.rd_data    = rd_data_w;
endmodule

// File: tb/tb_line_input_controller.sv
// Directed self-checking bench for line_input_controller.
module tb_line_input_controller;
  localparam int unsigned MAX_LEN = 32;

  logic CLOCK_50;
  logic reset;
  int   checks;
  int   failures;

  line_input_controller_if #(.MAX_LEN(MAX_LEN)) bus ();

  line_input_controller #(
    .MAX_LEN(MAX_LEN)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus.slave)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic key(input logic [7:0] k);
    bus.keycode     = k;
    bus.key_pressed = 1'b1;
    tick();
    bus.key_pressed = 1'b0;
  endtask

  task automatic ack();
    bus.line_ack = 1'b1;
    tick();
    bus.line_ack = 1'b0;
  endtask

  task automatic expect_echo(input string tag, input logic v, input logic [1:0] op,
                             input logic [31:0] pos, input logic [7:0] ch);
    check_eq({tag, ".valid"}, 32'(bus.echo_valid), 32'(v));
    if (v) begin
      check_eq({tag, ".op"},   32'(bus.echo_op),   32'(op));
      check_eq({tag, ".pos"},  32'(bus.echo_pos),  pos);
      check_eq({tag, ".char"}, 32'(bus.echo_char), 32'(ch));
    end
  endtask

  task automatic expect_state(input string tag, input logic rdy, input logic [31:0] len,
                              input logic ovf);
    check_eq({tag, ".ready"}, 32'(bus.line_ready), 32'(rdy));
    check_eq({tag, ".len"},   32'(bus.line_len),   len);
    check_eq({tag, ".ovf"},   32'(bus.overflow),   32'(ovf));
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    reset           = 1'b1;
    bus.key_pressed = 1'b0;
    bus.keycode     = 8'd0;
    bus.line_ack    = 1'b0;
    bus.rd_addr     = '0;
    repeat (3) tick();

    // Reset values
    expect_state("rst", 1'b0, 0, 1'b0);
    check_eq("rst.echo_valid", 32'(bus.echo_valid), 0);
    check_eq("rst.echo_op",    32'(bus.echo_op),    0);
    check_eq("rst.echo_pos",   32'(bus.echo_pos),   0);
    check_eq("rst.echo_char",  32'(bus.echo_char),  0);
    check_eq("rst.rd_data",    32'(bus.rd_data),    0);
    reset = 1'b0;
    tick();

    // A,B,C then Enter, read back the committed line
    key(8'd10); expect_echo("t1.w0", 1'b1, 2'd0, 0, 8'd10);
    key(8'd11); expect_echo("t1.w1", 1'b1, 2'd0, 1, 8'd11);
    key(8'd12); expect_echo("t1.w2", 1'b1, 2'd0, 2, 8'd12);
    key(8'd98); expect_echo("t1.enter", 1'b0, 2'd0, 0, 8'd0);
    expect_state("t1.hold", 1'b1, 3, 1'b0);
    bus.rd_addr = 5'd0; tick(); check_eq("t1.rd0", 32'(bus.rd_data), 10);
    bus.rd_addr = 5'd1; tick(); check_eq("t1.rd1", 32'(bus.rd_data), 11);
    bus.rd_addr = 5'd2; tick(); check_eq("t1.rd2", 32'(bus.rd_data), 12);
    ack(); expect_echo("t1.ack", 1'b1, 2'd2, 0, 8'd0);
    expect_state("t1.edit", 1'b0, 0, 1'b0);
    tick(); check_eq("t1.echo_one_cycle", 32'(bus.echo_valid), 0);

    // Delete down to empty and past it
    key(8'd1);  expect_echo("t2.w0", 1'b1, 2'd0, 0, 8'd1);
    key(8'd2);  expect_echo("t2.w1", 1'b1, 2'd0, 1, 8'd2);
    key(8'd37); expect_echo("t2.d1", 1'b1, 2'd1, 1, 8'd0);
    key(8'd37); expect_echo("t2.d0", 1'b1, 2'd1, 0, 8'd0);
    key(8'd37); expect_echo("t2.dx", 1'b0, 2'd0, 0, 8'd0);
    expect_state("t2.empty", 1'b0, 0, 1'b0);

    // Ignored codes and Esc on an empty line
    key(8'd100); expect_echo("t2.arrow", 1'b0, 2'd0, 0, 8'd0);
    key(8'd255); expect_echo("t2.unk",   1'b0, 2'd0, 0, 8'd0);
    key(8'd39);  expect_echo("t2.esc_empty", 1'b1, 2'd2, 0, 8'd0);

    // Fill past capacity, then Esc
    for (int i = 0; i < MAX_LEN + 2; i++) begin
      key(8'(i % 30));
      expect_echo($sformatf("t3.k%0d", i), (i < MAX_LEN), 2'd0, 32'(i), 8'(i % 30));
    end
    expect_state("t3.full", 1'b0, MAX_LEN, 1'b1);
    bus.rd_addr = 5'd31; tick(); check_eq("t3.rd31", 32'(bus.rd_data), 1);
    key(8'd39); expect_echo("t3.esc", 1'b1, 2'd2, 0, 8'd0);
    expect_state("t3.clr", 1'b0, 0, 1'b0);

    // Empty commit, keys during HOLD are dropped
    key(8'd98); expect_echo("t4.enter", 1'b0, 2'd0, 0, 8'd0);
    expect_state("t4.hold", 1'b1, 0, 1'b0);
    key(8'd5); expect_echo("t4.k5", 1'b0, 2'd0, 0, 8'd0);
    key(8'd6); expect_echo("t4.k6", 1'b0, 2'd0, 0, 8'd0);
    expect_state("t4.still", 1'b1, 0, 1'b0);
    ack(); expect_echo("t4.ack", 1'b1, 2'd2, 0, 8'd0);
    expect_state("t4.edit", 1'b0, 0, 1'b0);

    // Key coinciding with ack is dropped; next one is accepted
    key(8'd98);
    bus.keycode     = 8'd7;
    bus.key_pressed = 1'b1;
    bus.line_ack    = 1'b1;
    tick();
    bus.key_pressed = 1'b0;
    bus.line_ack    = 1'b0;
    expect_echo("t5.ack", 1'b1, 2'd2, 0, 8'd0);
    expect_state("t5.edit", 1'b0, 0, 1'b0);
    key(8'd7); expect_echo("t5.k7", 1'b1, 2'd0, 0, 8'd7);
    check_eq("t5.len", 32'(bus.line_len), 1);

    // Async reset while holding a 4-char line
    key(8'd1); key(8'd2); key(8'd3); key(8'd98);
    expect_state("t6.hold", 1'b1, 4, 1'b0);
    #5 reset = 1'b1;
    #1;
    expect_state("t6.async", 1'b0, 0, 1'b0);
    check_eq("t6.no_echo", 32'(bus.echo_valid), 0);
    tick();
    reset = 1'b0;
    bus.rd_addr = 5'd0;
    key(8'd8); expect_echo("t6.k8", 1'b1, 2'd0, 0, 8'd8);
    check_eq("t6.rd_old", 32'(bus.rd_data), 7);
    tick(); check_eq("t6.rd_new", 32'(bus.rd_data), 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
